// File: rtl/sorter_pkg.sv
// Shared definitions for the top-N sorter and its output collector:
// default sizes, sorter mode encodings and the collector state type.
package sorter_pkg;

  localparam int unsigned SORT_WIDTH = 8;
  localparam int unsigned SORT_N     = 16;

  typedef enum logic [1:0] {
    MODE_IDLE       = 2'd0,
    MODE_DESCENDING = 2'd1,
    MODE_ASCENDING  = 2'd2,
    MODE_FLUSH      = 2'd3
  } sort_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN
  } coll_state_e;

  // Address width for an n-entry buffer; a single entry still needs one bit.
  function automatic int unsigned addr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sort_collector_if.sv
// Signal bundle between the sorter output, the collector and the downstream sink.
// master = collector side, slave = surrounding logic driving sort_* and m_ready.
interface sort_collector_if #(
  parameter int unsigned WIDTH = sorter_pkg::SORT_WIDTH,
  parameter int unsigned N     = sorter_pkg::SORT_N
);
  localparam int unsigned LW = $clog2(N + 1);

  logic [WIDTH-1:0] sort_data;
  logic             sort_valid;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;
  logic [LW-1:0]    batch_len;
  logic             busy;
  logic             overflow;
  logic             order_err;

  modport master (
    input  sort_data, sort_valid, m_ready,
    output m_data, m_valid, m_last, batch_len, busy, overflow, order_err
  );

  modport slave (
    output sort_data, sort_valid, m_ready,
    input  m_data, m_valid, m_last, batch_len, busy, overflow, order_err
  );

endinterface

// File: rtl/sort_collector_buf.sv
// N x WIDTH batch store: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset.
module sort_collector_buf #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N     = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [N];

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sort_collector.sv
// Captures an unstallable sorter burst into a local buffer and replays it to a
// valid/ready sink with a last marker. Optional macro: SORT_COLLECTOR_ORDER_CHECK_EN.
module sort_collector
  import sorter_pkg::*;
#(
  parameter int unsigned WIDTH      = SORT_WIDTH,
  parameter int unsigned N          = SORT_N,
  parameter int unsigned GAP_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst,
  sort_collector_if.master io
);

  localparam int unsigned LW = $clog2(N + 1);
  localparam int unsigned AW = addr_w(N);
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  coll_state_e      r_state, w_next;
  logic [LW-1:0]    r_batch_len;
  logic [AW-1:0]    r_rd_ptr;
  logic [GW-1:0]    r_gap_cnt;
  logic             r_overflow;

  logic             w_wr_en;
  logic [AW-1:0]    w_wr_addr;
  logic [WIDTH-1:0] w_rd_data;
  logic             w_last;
  logic             w_hs;
  logic             w_fill_full;
  logic             w_gap_close;

  // Elements arriving while draining are dropped, never written.
  assign w_wr_en     = io.sort_valid && (r_state != ST_DRAIN);
  assign w_wr_addr   = (r_state == ST_FILL) ? r_batch_len[AW-1:0] : '0;
  assign w_last      = (r_state == ST_DRAIN) && (LW'(r_rd_ptr) == r_batch_len - LW'(1));
  assign w_hs        = (r_state == ST_DRAIN) && io.m_ready;
  assign w_fill_full = (r_batch_len + LW'(1)) == LW'(N);
  assign w_gap_close = r_gap_cnt == GW'(GAP_CYCLES - 1);

  sort_collector_buf #(
    .WIDTH (WIDTH),
    .N     (N),
    .AW    (AW)
  ) u_buf (
    .clk       (clk),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (io.sort_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (io.sort_valid) w_next = (N == 1) ? ST_DRAIN : ST_FILL;
      end
      ST_FILL: begin
        if (io.sort_valid) begin
          if (w_fill_full) w_next = ST_DRAIN;
        end else if (w_gap_close) begin
          w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (w_hs && w_last) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_batch_len <= '0;
      r_rd_ptr    <= '0;
      r_gap_cnt   <= '0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (io.sort_valid) begin
            r_batch_len <= LW'(1);
            r_gap_cnt   <= '0;
          end
        end
        ST_FILL: begin
          if (io.sort_valid) begin
            r_batch_len <= r_batch_len + LW'(1);
            r_gap_cnt   <= '0;
          end else if (r_gap_cnt != GW'(GAP_CYCLES)) begin
            r_gap_cnt   <= r_gap_cnt + GW'(1);
          end
        end
        ST_DRAIN: begin
          if (io.sort_valid) r_overflow <= 1'b1;
          if (w_hs)          r_rd_ptr   <= w_last ? '0 : r_rd_ptr + AW'(1);
        end
        default: ;
      endcase
    end
  end

  assign io.m_valid   = (r_state == ST_DRAIN);
  assign io.m_data    = w_rd_data;
  assign io.m_last    = w_last;
  assign io.batch_len = r_batch_len;
  assign io.busy      = (r_state != ST_IDLE);
  assign io.overflow  = r_overflow;

`ifdef SORT_COLLECTOR_ORDER_CHECK_EN
  logic [WIDTH-1:0] r_prev;
  logic             r_order_err;

  // The first element of a batch (accepted in IDLE) only seeds r_prev.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev      <= '0;
      r_order_err <= 1'b0;
    end else if (w_wr_en) begin
      r_prev <= io.sort_data;
      if ((r_state == ST_FILL) && (io.sort_data > r_prev)) r_order_err <= 1'b1;
    end
  end

  assign io.order_err = r_order_err;
`else
  assign io.order_err = 1'b0;
`endif

endmodule
